// File: rtl/lsq_alloc_ctrl_pkg.sv
// Shared LSQ definitions: queue sizes, tag types, and the allocation FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsq_alloc_ctrl_pkg;

    localparam int LQSIZE     = 64;
    localparam int SQSIZE     = 64;
    localparam int LQ_IDX_W   = $clog2(LQSIZE);
    localparam int SQ_IDX_W   = $clog2(SQSIZE);
    localparam int DISP_WIDTH = 4;
    localparam int DEQ_WIDTH  = 4;

    // Tags carry a flipped bit so that full (same idx, different lap) and
    // empty (identical pointers) are distinguishable.
    typedef struct packed {
        logic                flipped;
        logic [LQ_IDX_W-1:0] idx;
    } lqIdx_t;

    typedef struct packed {
        logic                flipped;
        logic [SQ_IDX_W-1:0] idx;
    } sqIdx_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } lsq_state_t;

    // Width of a count that must be able to represent the value SIZE itself.
    function automatic int lsq_cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/lsq_ptr_ctrl.sv
// Head/tail pointer bookkeeping for one circular queue: tag generation, advance, rollback, free count.
// Latency: tags combinational from tail_q; pointers and free count update one cycle after the request.
// Backpressure: none internally; the parent only asserts alloc_accept_i when the group fits in free_o.
//
// Ports:
//   alloc_req_i    per-slot "this slot needs an entry" (already masked with slot valid)
//   alloc_accept_i the whole dispatch group was accepted this cycle
//   deq_num_i      entries freed at the head this cycle
//   squash_vld_i / squash_ptr_i  roll the tail back to squash_ptr_i
//   tags_o         tail plus exclusive prefix count of alloc_req_i, one per slot
//   alloc_num_o    total entries requested by the group
//   head_o         oldest live entry
//   free_o         registered free-entry count, consistent with the registered pointers
module lsq_ptr_ctrl
    import lsq_alloc_ctrl_pkg::*;
#(
    parameter  int SIZE  = 64,
    parameter  int SLOTS = 4,
    parameter  int DEQ_W = 3,
    localparam int IDX_W = $clog2(SIZE),
    localparam int CNT_W = lsq_cnt_w(SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SLOTS-1:0]          alloc_req_i,
    input  logic                      alloc_accept_i,
    input  logic [DEQ_W-1:0]          deq_num_i,
    input  logic                      squash_vld_i,
    input  logic [IDX_W:0]            squash_ptr_i,
    output logic [SLOTS-1:0][IDX_W:0] tags_o,
    output logic [CNT_W-1:0]          alloc_num_o,
    output logic [IDX_W:0]            head_o,
    output logic [CNT_W-1:0]          free_o
);

    typedef logic [IDX_W:0] ptr_t;

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    logic [CNT_W-1:0] free_q, free_d;

    // Advance a {flipped, idx} pointer by n (n <= SIZE), toggling flipped on wrap.
    // Written with an explicit compare so non-power-of-two sizes also work.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] sum;
        logic [CNT_W-1:0] sum_wrapped;
        sum         = {1'b0, p[IDX_W-1:0]} + n;
        sum_wrapped = sum - SIZE_C;
        if (sum >= SIZE_C) begin
            ptr_add = {~p[IDX_W], sum_wrapped[IDX_W-1:0]};
        end else begin
            ptr_add = {p[IDX_W], sum[IDX_W-1:0]};
        end
    endfunction

    function automatic logic [CNT_W-1:0] occupancy(input ptr_t h, input ptr_t t);
        if (h[IDX_W] == t[IDX_W]) begin
            occupancy = {1'b0, t[IDX_W-1:0]} - {1'b0, h[IDX_W-1:0]};
        end else begin
            occupancy = SIZE_C - {1'b0, h[IDX_W-1:0]} + {1'b0, t[IDX_W-1:0]};
        end
    endfunction

    // Every slot gets a tag, memory op or not; non-memory slots simply see
    // the tag the next memory op in program order will receive.
    always_comb begin : tag_gen
        logic [CNT_W-1:0] pre;
        pre = '0;
        for (int i = 0; i < SLOTS; i++) begin
            tags_o[i] = ptr_add(tail_q, pre);
            pre       = pre + CNT_W'(alloc_req_i[i]);
        end
        alloc_num_o = pre;
    end

    always_comb begin
        head_d = ptr_add(head_q, CNT_W'(deq_num_i));
        tail_d = tail_q;
        if (squash_vld_i) begin
            tail_d = squash_ptr_i;
        end else if (alloc_accept_i) begin
            tail_d = ptr_add(tail_q, alloc_num_o);
        end
        // Computed from next-state pointers so the registered count never lags them.
        free_d = SIZE_C - occupancy(head_d, tail_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            free_q <= SIZE_C;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            free_q <= free_d;
        end
    end

    assign head_o = head_q;
    assign free_o = free_q;

    // Retiring more than is live would move the head past the tail.
    assert property (@(posedge clk) disable iff (rst)
        CNT_W'(deq_num_i) <= (SIZE_C - free_q));

    // A rollback target outside [head, tail] would resurrect freed entries.
    assert property (@(posedge clk) disable iff (rst)
        squash_vld_i |-> (occupancy(head_q, squash_ptr_i) <= occupancy(head_q, tail_q)));

endmodule

// File: rtl/lsq_alloc_ctrl.sv
// LQ/SQ allocation controller: hands out program-order tags, frees on retire, rolls back on squash.
// Latency: tags and o_can_disp combinational; pointers, heads and free counts update next cycle.
// Backpressure: whole group stalls (o_can_disp=0) on insufficient registered free space, squash, or RECOVER.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_disp_vld/isLoad/isStore        dispatch group, one bit per slot
//   o_can_disp                       group is accepted this cycle if any slot is valid
//   o_lqIdx, o_sqIdx                 per-slot LQ/SQ tags
//   i_lq_deq_num, i_sq_deq_num       entries freed at each head this cycle
//   i_squash_vld, i_squash_lqIdx/sqIdx  rollback request and new tails
//   o_lq_head, o_sq_head             oldest live entries
//   o_lq_free, o_sq_free             registered free counts
module lsq_alloc_ctrl #(
    parameter  int DISP_WIDTH = lsq_alloc_ctrl_pkg::DISP_WIDTH,
    parameter  int DEQ_WIDTH  = lsq_alloc_ctrl_pkg::DEQ_WIDTH,
    localparam int DEQ_W      = $clog2(DEQ_WIDTH) + 1,
    localparam int LQ_CNT_W   = lsq_alloc_ctrl_pkg::lsq_cnt_w(lsq_alloc_ctrl_pkg::LQSIZE),
    localparam int SQ_CNT_W   = lsq_alloc_ctrl_pkg::lsq_cnt_w(lsq_alloc_ctrl_pkg::SQSIZE)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DISP_WIDTH-1:0]                       i_disp_vld,
    input  logic [DISP_WIDTH-1:0]                       i_disp_isLoad,
    input  logic [DISP_WIDTH-1:0]                       i_disp_isStore,
    output logic                                        o_can_disp,
    output lsq_alloc_ctrl_pkg::lqIdx_t [DISP_WIDTH-1:0] o_lqIdx,
    output lsq_alloc_ctrl_pkg::sqIdx_t [DISP_WIDTH-1:0] o_sqIdx,
    input  logic [DEQ_W-1:0]                            i_lq_deq_num,
    input  logic [DEQ_W-1:0]                            i_sq_deq_num,
    input  logic                                        i_squash_vld,
    input  lsq_alloc_ctrl_pkg::lqIdx_t                  i_squash_lqIdx,
    input  lsq_alloc_ctrl_pkg::sqIdx_t                  i_squash_sqIdx,
    output lsq_alloc_ctrl_pkg::lqIdx_t                  o_lq_head,
    output lsq_alloc_ctrl_pkg::sqIdx_t                  o_sq_head,
    output logic [LQ_CNT_W-1:0]                         o_lq_free,
    output logic [SQ_CNT_W-1:0]                         o_sq_free
);

    import lsq_alloc_ctrl_pkg::*;

    lsq_state_t            state_q;
    logic [DISP_WIDTH-1:0] lq_req;
    logic [DISP_WIDTH-1:0] sq_req;
    logic [LQ_CNT_W-1:0]   lq_need;
    logic [SQ_CNT_W-1:0]   sq_need;
    logic                  accept;

    assign lq_req = i_disp_vld & i_disp_isLoad;
    assign sq_req = i_disp_vld & i_disp_isStore;

    // Uses the registered free counts, so entries freed this cycle only
    // become allocatable next cycle; keeps deq off the acceptance path.
    assign o_can_disp = (state_q == NORMAL) && !i_squash_vld &&
                        (lq_need <= o_lq_free) && (sq_need <= o_sq_free);
    assign accept     = o_can_disp && (|i_disp_vld);

    lsq_ptr_ctrl #(
        .SIZE  (LQSIZE),
        .SLOTS (DISP_WIDTH),
        .DEQ_W (DEQ_W)
    ) u_lq_ptr (
        .clk            (clk),
        .rst            (rst),
        .alloc_req_i    (lq_req),
        .alloc_accept_i (accept),
        .deq_num_i      (i_lq_deq_num),
        .squash_vld_i   (i_squash_vld),
        .squash_ptr_i   (i_squash_lqIdx),
        .tags_o         (o_lqIdx),
        .alloc_num_o    (lq_need),
        .head_o         (o_lq_head),
        .free_o         (o_lq_free)
    );

    lsq_ptr_ctrl #(
        .SIZE  (SQSIZE),
        .SLOTS (DISP_WIDTH),
        .DEQ_W (DEQ_W)
    ) u_sq_ptr (
        .clk            (clk),
        .rst            (rst),
        .alloc_req_i    (sq_req),
        .alloc_accept_i (accept),
        .deq_num_i      (i_sq_deq_num),
        .squash_vld_i   (i_squash_vld),
        .squash_ptr_i   (i_squash_sqIdx),
        .tags_o         (o_sqIdx),
        .alloc_num_o    (sq_need),
        .head_o         (o_sq_head),
        .free_o         (o_sq_free)
    );

    // One bubble after every squash gives downstream time to flush; a squash
    // arriving during RECOVER restarts that bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
        end else begin
            case (state_q)
                NORMAL:  if (i_squash_vld)  state_q <= RECOVER;
                RECOVER: if (!i_squash_vld) state_q <= NORMAL;
                default: state_q <= NORMAL;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (i_disp_vld & i_disp_isLoad & i_disp_isStore) == '0);

endmodule

// File: tb/tb_lsq_alloc_ctrl.sv
module tb_lsq_alloc_ctrl;

    localparam int DW = 4;
    localparam int PS = 128;   // pointer space: {flipped, idx} for SIZE=64
    localparam int SZ = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     vld, isl, iss;
    logic              can_disp;
    logic [DW-1:0][6:0] lq_idx, sq_idx;
    logic [2:0]        lq_deq, sq_deq;
    logic              sq_vld;
    logic [6:0]        sq_lq, sq_sq;
    logic [6:0]        lq_head, sq_head;
    logic [6:0]        lq_free, sq_free;

    int errors = 0;
    int checks = 0;

    // Reference model: pointers as plain integers modulo 2*SIZE.
    int m_lqh = 0, m_lqt = 0, m_sqh = 0, m_sqt = 0;
    bit m_rec = 0;

    always #5 clk = ~clk;

    lsq_alloc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_disp_vld     (vld),
        .i_disp_isLoad  (isl),
        .i_disp_isStore (iss),
        .o_can_disp     (can_disp),
        .o_lqIdx        (lq_idx),
        .o_sqIdx        (sq_idx),
        .i_lq_deq_num   (lq_deq),
        .i_sq_deq_num   (sq_deq),
        .i_squash_vld   (sq_vld),
        .i_squash_lqIdx (sq_lq),
        .i_squash_sqIdx (sq_sq),
        .o_lq_head      (lq_head),
        .o_sq_head      (sq_head),
        .o_lq_free      (lq_free),
        .o_sq_free      (sq_free)
    );

    function automatic int occ(input int h, input int t);
        return (t - h + PS) % PS;
    endfunction

    function automatic int cnt_before(input logic [DW-1:0] m, input int i);
        int c = 0;
        for (int j = 0; j < i; j++) c += int'(m[j]);
        return c;
    endfunction

    function automatic bit model_can();
        return !m_rec && !sq_vld &&
               (cnt_before(vld & isl, DW) <= SZ - occ(m_lqh, m_lqt)) &&
               (cnt_before(vld & iss, DW) <= SZ - occ(m_sqh, m_sqt));
    endfunction

    task automatic idle();
        vld = '0; isl = '0; iss = '0;
        lq_deq = '0; sq_deq = '0;
        sq_vld = 1'b0; sq_lq = '0; sq_sq = '0;
    endtask

    // One clock: model consumes the inputs held across the edge; returns at negedge.
    task automatic tick();
        int  nl, ns;
        bit  acc;
        nl  = cnt_before(vld & isl, DW);
        ns  = cnt_before(vld & iss, DW);
        acc = model_can() && (vld != '0);
        @(posedge clk);
        if (rst) begin
            m_lqh = 0; m_lqt = 0; m_sqh = 0; m_sqt = 0; m_rec = 0;
        end else begin
            m_lqh = (m_lqh + int'(lq_deq)) % PS;
            m_sqh = (m_sqh + int'(sq_deq)) % PS;
            if (sq_vld) begin
                m_lqt = int'(sq_lq);
                m_sqt = int'(sq_sq);
            end else if (acc) begin
                m_lqt = (m_lqt + nl) % PS;
                m_sqt = (m_sqt + ns) % PS;
            end
            m_rec = sq_vld;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_lq(input int n);
        int k;
        while (n > 0) begin
            k   = (n > DW) ? DW : n;
            vld = 4'((1 << k) - 1);
            isl = vld;
            tick();
            n -= k;
        end
        idle();
    endtask

    task automatic drain_lq(input int n);
        int k;
        while (n > 0) begin
            k      = (n > DW) ? DW : n;
            lq_deq = 3'(k);
            tick();
            n -= k;
        end
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        fill_lq(10);
        // Reset mid-operation with junk requests present.
        rst = 1'b1;
        vld = 4'hF; isl = 4'hF; lq_deq = 3'd2; sq_vld = 1'b1; sq_lq = 7'd5;
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL reset_can_disp: got %0d expected 1", can_disp); end
        checks++; if (lq_free !== 7'd64) begin errors++; $display("FAIL reset_lq_free: got %0d expected 64", lq_free); end
        checks++; if (sq_free !== 7'd64) begin errors++; $display("FAIL reset_sq_free: got %0d expected 64", sq_free); end
        checks++; if (lq_head !== 7'd0) begin errors++; $display("FAIL reset_lq_head: got %0d expected 0", lq_head); end
        checks++; if (sq_head !== 7'd0) begin errors++; $display("FAIL reset_sq_head: got %0d expected 0", sq_head); end
        for (int i = 0; i < DW; i++) begin
            checks++; if (lq_idx[i] !== 7'd0) begin errors++; $display("FAIL reset_lq_tag[%0d]: got %0d expected 0", i, lq_idx[i]); end
            checks++; if (sq_idx[i] !== 7'd0) begin errors++; $display("FAIL reset_sq_tag[%0d]: got %0d expected 0", i, sq_idx[i]); end
        end
        tick();
        #1;
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL reset_no_recover: got %0d expected 1", can_disp); end
    endtask

    task automatic test_four_loads();
        do_reset();
        vld = 4'hF; isl = 4'hF;
        #1;
        for (int i = 0; i < DW; i++) begin
            checks++; if (lq_idx[i] !== 7'(i)) begin errors++; $display("FAIL four_loads_tag[%0d]: got %0d expected %0d", i, lq_idx[i], i); end
        end
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL four_loads_can_disp: got %0d expected 1", can_disp); end
        tick();
        idle();
        #1;
        checks++; if (lq_free !== 7'd60) begin errors++; $display("FAIL four_loads_free: got %0d expected 60", lq_free); end
        checks++; if (lq_idx[0] !== 7'd4) begin errors++; $display("FAIL four_loads_tail: got %0d expected 4", lq_idx[0]); end
    endtask

    task automatic test_mixed();
        logic [DW-1:0][6:0] exp_lq, exp_sq;
        exp_lq = {7'd2, 7'd1, 7'd1, 7'd0};
        exp_sq = {7'd1, 7'd1, 7'd0, 7'd0};
        do_reset();
        vld = 4'hF; isl = 4'b0101; iss = 4'b1010;   // slots 0..3 = L,S,L,S
        #1;
        for (int i = 0; i < DW; i++) begin
            checks++; if (lq_idx[i] !== exp_lq[i]) begin errors++; $display("FAIL mixed_lq_tag[%0d]: got %0d expected %0d", i, lq_idx[i], exp_lq[i]); end
            checks++; if (sq_idx[i] !== exp_sq[i]) begin errors++; $display("FAIL mixed_sq_tag[%0d]: got %0d expected %0d", i, sq_idx[i], exp_sq[i]); end
        end
        tick();
        idle();
        #1;
        checks++; if (lq_free !== 7'd62) begin errors++; $display("FAIL mixed_lq_free: got %0d expected 62", lq_free); end
        checks++; if (sq_free !== 7'd62) begin errors++; $display("FAIL mixed_sq_free: got %0d expected 62", sq_free); end
    endtask

    task automatic test_full();
        do_reset();
        fill_lq(62);
        vld = 4'b0111; isl = 4'b0111;
        #1;
        checks++; if (lq_free !== 7'd2) begin errors++; $display("FAIL full_free62: got %0d expected 2", lq_free); end
        checks++; if (can_disp !== 1'b0) begin errors++; $display("FAIL full_reject: got %0d expected 0", can_disp); end
        tick();
        #1;
        checks++; if (lq_idx[0] !== 7'd62) begin errors++; $display("FAIL full_tail_held: got %0d expected 62", lq_idx[0]); end
        // Dequeue in the same cycle does not help until the next cycle.
        lq_deq = 3'd1;
        #1;
        checks++; if (can_disp !== 1'b0) begin errors++; $display("FAIL full_deq_same_cycle: got %0d expected 0", can_disp); end
        tick();
        lq_deq = 3'd0;
        #1;
        checks++; if (lq_free !== 7'd3) begin errors++; $display("FAIL full_free3: got %0d expected 3", lq_free); end
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL full_accept: got %0d expected 1", can_disp); end
        tick();
        idle();
        #1;
        checks++; if (lq_free !== 7'd0) begin errors++; $display("FAIL full_free0: got %0d expected 0", lq_free); end
        checks++; if (lq_idx[0] !== 7'b1000001) begin errors++; $display("FAIL full_tail_flip: got %0d expected 65", lq_idx[0]); end
        checks++; if (lq_head !== 7'd1) begin errors++; $display("FAIL full_head: got %0d expected 1", lq_head); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0][6:0] exp_lq;
        exp_lq = {7'b1000001, 7'b1000000, 7'd63, 7'd62};
        do_reset();
        fill_lq(62);
        drain_lq(62);
        #1;
        checks++; if (lq_head !== 7'd62) begin errors++; $display("FAIL wrap_head: got %0d expected 62", lq_head); end
        checks++; if (lq_free !== 7'd64) begin errors++; $display("FAIL wrap_empty_free: got %0d expected 64", lq_free); end
        vld = 4'hF; isl = 4'hF;
        #1;
        for (int i = 0; i < DW; i++) begin
            checks++; if (lq_idx[i] !== exp_lq[i]) begin errors++; $display("FAIL wrap_tag[%0d]: got %0d expected %0d", i, lq_idx[i], exp_lq[i]); end
        end
        tick();
        idle();
        #1;
        checks++; if (lq_idx[0] !== 7'b1000010) begin errors++; $display("FAIL wrap_tail: got %0d expected 66", lq_idx[0]); end
        checks++; if (lq_free !== 7'd60) begin errors++; $display("FAIL wrap_free: got %0d expected 60", lq_free); end
    endtask

    task automatic test_squash();
        do_reset();
        fill_lq(20);
        vld = 4'hF; isl = 4'hF; lq_deq = 3'd2;
        sq_vld = 1'b1; sq_lq = 7'd12; sq_sq = 7'd0;
        #1;
        checks++; if (can_disp !== 1'b0) begin errors++; $display("FAIL squash_blocks_disp: got %0d expected 0", can_disp); end
        tick();
        idle();
        #1;
        checks++; if (lq_idx[0] !== 7'd12) begin errors++; $display("FAIL squash_tail: got %0d expected 12", lq_idx[0]); end
        checks++; if (lq_head !== 7'd2) begin errors++; $display("FAIL squash_head: got %0d expected 2", lq_head); end
        checks++; if (lq_free !== 7'd54) begin errors++; $display("FAIL squash_free: got %0d expected 54", lq_free); end
        checks++; if (can_disp !== 1'b0) begin errors++; $display("FAIL squash_recover: got %0d expected 0", can_disp); end
        tick();
        #1;
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL squash_resume: got %0d expected 1", can_disp); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_lq(20);
        sq_vld = 1'b1; sq_lq = 7'd15;
        tick();
        sq_lq = 7'd10;
        tick();
        idle();
        #1;
        checks++; if (can_disp !== 1'b0) begin errors++; $display("FAIL b2b_recover_held: got %0d expected 0", can_disp); end
        checks++; if (lq_idx[0] !== 7'd10) begin errors++; $display("FAIL b2b_tail: got %0d expected 10", lq_idx[0]); end
        tick();
        #1;
        checks++; if (can_disp !== 1'b1) begin errors++; $display("FAIL b2b_resume: got %0d expected 1", can_disp); end
    endtask

    task automatic test_random();
        int lo, so, r;
        bit deq_en;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < DW; i++) begin
                r      = int'($urandom_range(0, 4));
                isl[i] = (r == 1 || r == 2);
                iss[i] = (r == 3 || r == 4);
            end
            vld    = 4'($urandom) | 4'($urandom);
            // Alternate fill-heavy and drain-heavy phases so both queues reach full.
            deq_en = ((cyc / 64) % 2) == 1 || ($urandom_range(0, 7) == 0);
            lo     = occ(m_lqh, m_lqt);
            so     = occ(m_sqh, m_sqt);
            lq_deq = deq_en ? 3'($urandom_range(0, (lo > 4) ? 4 : lo)) : 3'd0;
            sq_deq = deq_en ? 3'($urandom_range(0, (so > 4) ? 4 : so)) : 3'd0;
            if ($urandom_range(0, 11) == 0) begin
                sq_vld = 1'b1;
                sq_lq  = 7'((m_lqh + int'(lq_deq) + int'($urandom_range(0, lo - int'(lq_deq)))) % PS);
                sq_sq  = 7'((m_sqh + int'(sq_deq) + int'($urandom_range(0, so - int'(sq_deq)))) % PS);
            end else begin
                sq_vld = 1'b0; sq_lq = '0; sq_sq = '0;
            end
            #1;
            checks++; if (can_disp !== model_can()) begin errors++; $display("FAIL rnd_can_disp cyc%0d: got %0d expected %0d", cyc, can_disp, model_can()); end
            for (int i = 0; i < DW; i++) begin
                checks++; if (lq_idx[i] !== 7'((m_lqt + cnt_before(vld & isl, i)) % PS)) begin
                    errors++; $display("FAIL rnd_lq_tag[%0d] cyc%0d: got %0d expected %0d", i, cyc, lq_idx[i], (m_lqt + cnt_before(vld & isl, i)) % PS);
                end
                checks++; if (sq_idx[i] !== 7'((m_sqt + cnt_before(vld & iss, i)) % PS)) begin
                    errors++; $display("FAIL rnd_sq_tag[%0d] cyc%0d: got %0d expected %0d", i, cyc, sq_idx[i], (m_sqt + cnt_before(vld & iss, i)) % PS);
                end
            end
            tick();
            checks++; if (lq_head !== 7'(m_lqh)) begin errors++; $display("FAIL rnd_lq_head cyc%0d: got %0d expected %0d", cyc, lq_head, m_lqh); end
            checks++; if (sq_head !== 7'(m_sqh)) begin errors++; $display("FAIL rnd_sq_head cyc%0d: got %0d expected %0d", cyc, sq_head, m_sqh); end
            checks++; if (lq_free !== 7'(SZ - occ(m_lqh, m_lqt))) begin errors++; $display("FAIL rnd_lq_free cyc%0d: got %0d expected %0d", cyc, lq_free, SZ - occ(m_lqh, m_lqt)); end
            checks++; if (sq_free !== 7'(SZ - occ(m_sqh, m_sqt))) begin errors++; $display("FAIL rnd_sq_free cyc%0d: got %0d expected %0d", cyc, sq_free, SZ - occ(m_sqh, m_sqt)); end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_four_loads();
        test_mixed();
        test_full();
        test_wrap();
        test_squash();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
